// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//   Read-only, byte-organised instruction store for the rv32i fetch stage with
//   a registered valid/ready request/response interface. One request is
//   outstanding at a time; each returns a little-endian 32-bit instruction (or
//   a fault) WAIT_STATES+1 cycles after acceptance.
//
//   The text image is supplied at elaboration through INIT_IMAGE, a packed
//   vector whose byte i (bits 8*i+7:8*i) is the byte at address MEM_ORG+i.
//
// Parameters:
//   MEM_ORG      first valid byte address
//   MEM_END      one past the last valid byte address
//   INIT_IMAGE   contents of MEM_ORG..MEM_END-1, byte 0 in bits 7:0
//   WAIT_STATES  extra cycles (0..15) between acceptance and response
//   ALIGN_BYTES  required fetch alignment: 4, or 2 for compressed-capable fetch
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  fetch request valid
//   req_ready_o  request accepted when valid and ready are both high
//   req_addr_i   byte address of the instruction
//   rsp_valid_o  response valid
//   rsp_ready_i  consumer accepts the response
//   rsp_instr_o  bytes addr..addr+3, byte at addr in bits 7:0
//   rsp_fault_o  misaligned or out-of-range fetch, qualified by rsp_valid_o
//   rsp_addr_o   address of the request being answered
// -----------------------------------------------------------------------------
module instruction_memory #(
  parameter logic [31:0]                      MEM_ORG     = 32'h0000_0100,
  parameter logic [31:0]                      MEM_END     = 32'h0000_0200,
  parameter logic [8*(MEM_END-MEM_ORG)-1:0]   INIT_IMAGE  = '0,
  parameter int unsigned                      WAIT_STATES = 0,
  parameter int unsigned                      ALIGN_BYTES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_instr_o,
  output logic        rsp_fault_o,
  output logic [31:0] rsp_addr_o
);

  localparam int unsigned IMG_BITS   = 8 * (MEM_END - MEM_ORG);
  localparam int unsigned IDX_W      = $clog2(IMG_BITS);
  localparam logic [31:0] ALIGN_MASK = 32'(ALIGN_BYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Where an accepted request goes: straight to RESP without wait states.
  localparam logic [1:0] ACCEPT_STATE = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
  localparam logic [3:0] ACCEPT_CNT   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  if ((WAIT_STATES > 15) || ((ALIGN_BYTES != 4) && (ALIGN_BYTES != 2))) begin : g_param_check
    $error("instruction_memory: WAIT_STATES must be 0..15 and ALIGN_BYTES 2 or 4");
  end

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q;
  logic             accept;
  logic             load_rsp;
  logic [31:0]      sel_addr;
  logic [32:0]      sel_end;
  logic             sel_fault;
  logic [IDX_W-1:0] bit_idx;
  logic [31:0]      sel_instr;

  // Next-state, handshake and response-load decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    accept      = 1'b0;
    load_rsp    = 1'b0;

    case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_RESP: req_ready_o = rsp_ready_i;
      default: req_ready_o = 1'b0;
    endcase

    accept = req_valid_i && req_ready_o;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ACCEPT_STATE;
          cnt_d   = ACCEPT_CNT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (accept) begin
          state_d = ACCEPT_STATE;
          cnt_d   = ACCEPT_CNT;
        end else if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Response regs load only on entry into RESP (including RESP->RESP refill).
    load_rsp = (state_d == ST_RESP) && ((state_q != ST_RESP) || accept);
  end

  // With zero wait states RESP is entered on the accepting edge, so the live
  // request address is used; otherwise the latched one.
  always_comb begin
    sel_addr  = accept ? req_addr_i : addr_q;
    sel_end   = {1'b0, sel_addr} + 33'd4;
    sel_fault = ((sel_addr & ALIGN_MASK) != 32'd0) ||
                (sel_addr < MEM_ORG) ||
                (sel_end > {1'b0, MEM_END});
    bit_idx   = IDX_W'((sel_addr - MEM_ORG) << 3);
    sel_instr = sel_fault ? 32'h0000_0000 : INIT_IMAGE[bit_idx +: 32];
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Wait counter, request address and registered response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      rsp_valid_o <= 1'b0;
      rsp_instr_o <= 32'd0;
      rsp_fault_o <= 1'b0;
      rsp_addr_o  <= 32'd0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_valid_o <= (state_d == ST_RESP);
      if (accept) addr_q <= req_addr_i;
      if (load_rsp) begin
        rsp_instr_o <= sel_instr;
        rsp_fault_o <= sel_fault;
        rsp_addr_o  <= sel_addr;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//   Three instances sharing one 256-byte image at 0x100..0x1FF:
//     dut 0: WAIT_STATES=0, ALIGN_BYTES=4
//     dut 1: WAIT_STATES=3, ALIGN_BYTES=4
//     dut 2: WAIT_STATES=5, ALIGN_BYTES=2
//   Image: bytes 0x100..0x103 = 13 05 a0 00, every other byte at 0x100+i = i.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

  localparam int unsigned NDUT = 3;

  function automatic logic [2047:0] mk_image();
    logic [2047:0] img;
    img = '0;
    for (int i = 0; i < 256; i++) img[8*i +: 8] = 8'(i);
    img[31:0] = 32'h00A0_0513;
    return img;
  endfunction

  localparam logic [2047:0] IMAGE = mk_image();

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
  logic [31:0]     req_addr  [NDUT];
  logic [31:0]     rsp_instr [NDUT];
  logic [31:0]     rsp_addr  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    instruction_memory #(
      .MEM_ORG    (32'h0000_0100),
      .MEM_END    (32'h0000_0200),
      .INIT_IMAGE (IMAGE),
      .WAIT_STATES((g == 0) ? 32'd0 : ((g == 1) ? 32'd3 : 32'd5)),
      .ALIGN_BYTES((g == 2) ? 32'd2 : 32'd4)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_addr_i (req_addr[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready[g]),
      .rsp_instr_o(rsp_instr[g]),
      .rsp_fault_o(rsp_fault[g]),
      .rsp_addr_o (rsp_addr[g])
    );
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [12];

  // Single fetch: checks latency, payload, ready during wait/hold, then completes.
  task automatic fetch(input string tag, input int k, input logic [31:0] addr,
                       input logic [31:0] exp_instr, input logic exp_fault,
                       input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    rsp_ready[k] = 1'b0;
    chk({tag, " req_ready idle"}, 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_addr[k]  = 32'hDEAD_BEE0;
    lat = 0;
    while (!rsp_valid[k] && lat < 20) begin
      chk({tag, " req_ready in wait"}, 32'(req_ready[k]), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " instr"}, rsp_instr[k], exp_instr);
    chk({tag, " fault"}, 32'(rsp_fault[k]), 32'(exp_fault));
    chk({tag, " addr"}, rsp_addr[k], addr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(rsp_valid[k]), 32'd1);
      chk({tag, " hold instr"}, rsp_instr[k], exp_instr);
      chk({tag, " hold addr"}, rsp_addr[k], addr);
      chk({tag, " hold req_ready"}, 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk({tag, " valid after accept"}, 32'(rsp_valid[k]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 32'h0000_0100, 32'h00A0_0513, 1'b0, 0, 0};
    vecs[1]  = '{0, 32'h0000_0104, 32'h0706_0504, 1'b0, 0, 0};
    vecs[2]  = '{0, 32'h0000_01FC, 32'hFFFE_FDFC, 1'b0, 0, 0};
    vecs[3]  = '{0, 32'h0000_0102, 32'h0000_0000, 1'b1, 0, 0};
    vecs[4]  = '{0, 32'h0000_00FC, 32'h0000_0000, 1'b1, 0, 0};
    vecs[5]  = '{0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 0, 0};
    vecs[6]  = '{0, 32'h0000_0200, 32'h0000_0000, 1'b1, 0, 0};
    vecs[7]  = '{1, 32'h0000_0104, 32'h0706_0504, 1'b0, 3, 3};
    vecs[8]  = '{1, 32'h0000_0102, 32'h0000_0000, 1'b1, 3, 0};
    vecs[9]  = '{2, 32'h0000_01FE, 32'h0000_0000, 1'b1, 5, 0};
    vecs[10] = '{2, 32'h0000_01FA, 32'hFDFC_FBFA, 1'b0, 5, 0};
    vecs[11] = '{1, 32'h0000_01FC, 32'hFFFE_FDFC, 1'b0, 3, 0};

    rst       = '1;
    req_valid = '0;
    rsp_ready = '0;
    for (int k = 0; k < NDUT; k++) req_addr[k] = 32'd0;
    repeat (3) @(negedge clk);
    rst = '0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("reset dut%0d req_ready", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("reset dut%0d rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("reset dut%0d rsp_instr", k), rsp_instr[k], 32'd0);
      chk($sformatf("reset dut%0d rsp_fault", k), 32'(rsp_fault[k]), 32'd0);
      chk($sformatf("reset dut%0d rsp_addr", k), rsp_addr[k], 32'd0);
    end

    for (int i = 0; i < 12; i++)
      fetch($sformatf("vec%0d", i), vecs[i].k, vecs[i].addr, vecs[i].instr,
            vecs[i].fault, vecs[i].lat, vecs[i].hold);

    // Back-to-back on dut 0: one response per cycle, no bubbles.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_0100;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("b2b0 valid", 32'(rsp_valid[0]), 32'd1);
    chk("b2b0 addr", rsp_addr[0], 32'h0000_0100);
    chk("b2b0 instr", rsp_instr[0], 32'h00A0_0513);
    chk("b2b0 req_ready", 32'(req_ready[0]), 32'd1);
    req_addr[0] = 32'h0000_0104;
    @(negedge clk);
    chk("b2b1 valid", 32'(rsp_valid[0]), 32'd1);
    chk("b2b1 addr", rsp_addr[0], 32'h0000_0104);
    chk("b2b1 instr", rsp_instr[0], 32'h0706_0504);
    req_addr[0] = 32'h0000_0108;
    @(negedge clk);
    chk("b2b2 valid", 32'(rsp_valid[0]), 32'd1);
    chk("b2b2 addr", rsp_addr[0], 32'h0000_0108);
    chk("b2b2 instr", rsp_instr[0], 32'h0B0A_0908);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b end valid", 32'(rsp_valid[0]), 32'd0);
    rsp_ready[0] = 1'b0;

    // Asynchronous reset two cycles into WAIT on dut 2: request is dropped.
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("rstwait ready before", 32'(req_ready[2]), 32'd0);
    #2 rst[2] = 1'b1;
    #1;
    chk("rstwait async ready", 32'(req_ready[2]), 32'd1);
    chk("rstwait async valid", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rstwait no response", 32'(rsp_valid[2]), 32'd0);
    end
    fetch("rstwait after", 2, 32'h0000_0104, 32'h0706_0504, 1'b0, 5, 0);

    // Asynchronous reset while a response is held on dut 1.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h0000_0108;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstresp valid before", 32'(rsp_valid[1]), 32'd1);
    chk("rstresp instr before", rsp_instr[1], 32'h0B0A_0908);
    #2 rst[1] = 1'b1;
    #1;
    chk("rstresp async valid", 32'(rsp_valid[1]), 32'd0);
    chk("rstresp async instr", rsp_instr[1], 32'd0);
    chk("rstresp async addr", rsp_addr[1], 32'd0);
    chk("rstresp async ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    rst[1] = 1'b0;
    fetch("rstresp after", 1, 32'h0000_0100, 32'h00A0_0513, 1'b0, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
Parametrised, byte-organised, read-only instruction store for the rv32i core with a registered valid/ready fetch interface. Each request returns one little-endian 32-bit instruction after a configurable number of wait states, or a fetch fault. It replaces the combinational fetch path and sits between the fetch stage and the text image loaded at elaboration. One request is outstanding at a time; back-to-back fetches sustain one instruction per (WAIT_STATES+1) cycles.

Parameters:
MEM_ORG, TEXT_ORG (definitions_pkg), first valid byte address
MEM_END, TEXT_END (definitions_pkg), one past last valid byte address
INIT_FILE, FNAME_TEXT (definitions_pkg), hex image loaded with $readmemh at time zero
WAIT_STATES, 0, extra cycles (0..15) between request acceptance and response
ALIGN_BYTES, 4, required fetch alignment; legal values 4, or 2 for compressed-capable fetch

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
req_valid_i  input  1  fetch request valid
req_ready_o  output  1  request accepted when valid and ready are both high
req_addr_i  input  32 (word_ut)  byte address of instruction
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  consumer accepts response
rsp_instr_o  output  32 (word_ut)  instruction, bytes addr..addr+3, byte at addr in bits 7:0
rsp_fault_o  output  1  fetch fault (misaligned or out of range), qualified by rsp_valid_o
rsp_addr_o  output  32 (word_ut)  address of the request being answered

Behaviour:
- Storage: byte array indexed MEM_ORG..MEM_END-1, filled from INIT_FILE at time zero; rst_i does not clear contents; no write port.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch address, compute fault, go WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else RESP.
- WAIT: req_ready_o=0. Counter decrements each cycle; at 0 go RESP next edge.
- RESP: rsp_valid_o=1; rsp_instr_o/rsp_fault_o/rsp_addr_o held stable until handshake. req_ready_o = rsp_ready_i (combinational).
- In RESP, rsp_ready_i=1 and req_valid_i=1: new request accepted the same cycle; next state WAIT or RESP as from IDLE. rsp_ready_i=1 with no new request: go IDLE.
- Latency: with WAIT_STATES=0, request accepted at edge N gives rsp_valid_o high in the cycle after edge N; in general rsp_valid_o rises WAIT_STATES+1 cycles after acceptance.
- Data is read from the array at the cycle the response is registered; output regs are loaded only on the transition into RESP.
- Fault: addr mod ALIGN_BYTES != 0, addr < MEM_ORG, or addr+4 > MEM_END (computed in 33 bits, so addresses near 0xFFFF_FFFF do not wrap). On fault, rsp_instr_o=32'h0000_0000 and no array access is made. Fault responses take the same latency as normal responses.
- ALIGN_BYTES=2: halfword-aligned fetch at MEM_END-2 faults, since all 4 bytes must be in range.
- Reset (asynchronous, any state): state IDLE, counter 0, rsp_valid_o=0, rsp_fault_o=0, rsp_instr_o=0, rsp_addr_o=0. A pending request is discarded with no response. req_ready_o=1 after rst_i deasserts.
- req_addr_i is ignored unless the handshake occurs; changing it while ready is low has no effect.

Test Plan:
- Test config MEM_ORG=0x100, MEM_END=0x200, WAIT_STATES=0, image bytes 0x100..0x103 = 13 05 a0 00. Request 0x100 -> next cycle rsp_valid_o=1, rsp_instr_o=0x00A00513, rsp_fault_o=0, rsp_addr_o=0x100.
- WAIT_STATES=3, request 0x104 accepted at edge N -> rsp_valid_o rises in the 4th cycle after acceptance. req_ready_o=0 during WAIT. Response holds 3 cycles with rsp_ready_i=0, then completes.
- WAIT_STATES=0, rsp_ready_i=1, req_valid_i held for addresses 0x100,0x104,0x108 -> three consecutive cycles of rsp_valid_o with matching rsp_addr_o and no bubbles.
- Faults: 0x102 (ALIGN_BYTES=4), 0x0FC, 0x1FE (ALIGN_BYTES=2), 0xFFFF_FFFC -> rsp_fault_o=1, rsp_instr_o=0 each, same latency as a good fetch.
- Assert rst_i asynchronously mid-WAIT (WAIT_STATES=5, 2 cycles in) -> rsp_valid_o=0 immediately, no response ever appears for that request, next request after release behaves normally.
- Request 0x1FC (last word) -> valid, no fault, data = bytes 0x1FC..0x1FF little-endian.
